// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter and scoreboard.
package rf_wb_arbiter_pkg;

    localparam int XLEN       = 64;
    localparam int REG_BUS    = XLEN;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic {
        WB_SRC_EXE = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic is_nonzero_reg(input logic [REG_ADDR_W-1:0] r);
        return r != '0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// In-flight destination scoreboard with RAW/WAW hazard detection for the issue stage.
// Optional feature: RF_WB_BYPASS_EN lets a pending write-back satisfy a RAW dependency.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic                  issue_wen_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] issue_rs1_i,
    input  logic [REG_ADDR_W-1:0] issue_rs2_i,
    input  logic                  wb_wen_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    output logic                  issue_stall_o,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic pend_rs1, pend_rs2, pend_rd;
    logic raw1, raw2, waw;
    logic set_en;

    assign pend_rs1 = wb_wen_i && (wb_addr_i == issue_rs1_i);
    assign pend_rs2 = wb_wen_i && (wb_addr_i == issue_rs2_i);
    assign pend_rd  = wb_wen_i && (wb_addr_i == issue_rd_i);

`ifdef RF_WB_BYPASS_EN
    // The pending write is forwarded, so its still-set busy bit must not block the reader.
    assign raw1 = is_nonzero_reg(issue_rs1_i) && busy_q[issue_rs1_i] && !pend_rs1;
    assign raw2 = is_nonzero_reg(issue_rs2_i) && busy_q[issue_rs2_i] && !pend_rs2;
`else
    assign raw1 = is_nonzero_reg(issue_rs1_i) && (busy_q[issue_rs1_i] || pend_rs1);
    assign raw2 = is_nonzero_reg(issue_rs2_i) && (busy_q[issue_rs2_i] || pend_rs2);
`endif
    assign waw  = issue_wen_i && is_nonzero_reg(issue_rd_i) && (busy_q[issue_rd_i] || pend_rd);

    assign issue_stall_o = issue_valid_i && (raw1 || raw2 || waw);
    assign set_en        = issue_valid_i && issue_wen_i && !issue_stall_o && is_nonzero_reg(issue_rd_i);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (wb_wen_i) busy_d[wb_addr_i] = 1'b0;
        // Set after clear: a newly issued producer owns the register.
        if (set_en) busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter (EXE vs LSU) driving the register file write port.
// Optional feature: RF_WB_BYPASS_EN adds forwarding outputs from the registered write.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    output logic                  exe_ready,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic [XLEN-1:0]       exe_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    output logic                  issue_stall,
    output logic [NUM_REGS-1:0]   sb_busy
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd1_data,
    output logic [XLEN-1:0]       fwd2_data
`endif
);

    wb_src_e last_grant_q, last_grant_d;
    wb_req_t out_q, out_d;
    logic    grant_exe, grant_lsu;

    // Grant doubles as ready, so a grant always completes a handshake.
    always_comb begin
        grant_exe = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (exe_valid && lsu_valid) begin
                grant_exe = (last_grant_q == WB_SRC_LSU);
                grant_lsu = !grant_exe;
            end else begin
                grant_exe = exe_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign exe_ready = grant_exe;
    assign lsu_ready = grant_lsu;

    always_comb begin
        out_d        = out_q;
        out_d.wen    = 1'b0;
        last_grant_d = last_grant_q;
        if (grant_exe) begin
            out_d        = '{wen: is_nonzero_reg(exe_rd), rd: exe_rd, data: exe_data};
            last_grant_d = WB_SRC_EXE;
        end else if (grant_lsu) begin
            out_d        = '{wen: is_nonzero_reg(lsu_rd), rd: lsu_rd, data: lsu_data};
            last_grant_d = WB_SRC_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '{wen: 1'b0, rd: '0, data: ZERO_WORD};
            last_grant_q <= WB_SRC_LSU;
        end else begin
            out_q        <= out_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rf_wen   = out_q.wen;
    assign rf_waddr = out_q.rd;
    assign rf_wdata = out_q.data;

    rf_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid),
        .issue_wen_i  (issue_wen),
        .issue_rd_i   (issue_rd),
        .issue_rs1_i  (issue_rs1),
        .issue_rs2_i  (issue_rs2),
        .wb_wen_i     (out_q.wen),
        .wb_addr_i    (out_q.rd),
        .issue_stall_o(issue_stall),
        .busy_o       (sb_busy)
    );

`ifdef RF_WB_BYPASS_EN
    assign fwd1_hit  = out_q.wen && (out_q.rd == issue_rs1) && is_nonzero_reg(issue_rs1);
    assign fwd2_hit  = out_q.wen && (out_q.rd == issue_rs2) && is_nonzero_reg(issue_rs2);
    assign fwd1_data = out_q.data;
    assign fwd2_data = out_q.data;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; also builds with RF_WB_BYPASS_EN defined.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        exe_valid, lsu_valid;
    logic        exe_ready, lsu_ready;
    logic [4:0]  exe_rd, lsu_rd;
    logic [63:0] exe_data, lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic [31:0] sb_busy;
`ifdef RF_WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [63:0] fwd1_data, fwd2_data;
`endif

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_rd(exe_rd), .exe_data(exe_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .sb_busy(sb_busy)
`ifdef RF_WB_BYPASS_EN
        ,
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        exe_valid = 0; exe_rd = 0; exe_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    endtask

    task automatic do_reset();
        step(); rst = 1; clear_inputs();
        step(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        step(); exe_valid = 1; exe_rd = 5; exe_data = 64'h1234; lsu_valid = 1; lsu_rd = 6;
        sample();
        checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL reset_exe_ready: got %0b want 0", exe_ready); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %0b want 0", lsu_ready); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %0b want 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        checks++; if (sb_busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", sb_busy); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd1_hit: got %0b want 0", fwd1_hit); end
`endif
        step(); rst = 0; clear_inputs();
        sample();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %0b want 0", rf_wen); end
    endtask

    task automatic test_exe_only();
        step(); exe_valid = 1; exe_rd = 5; exe_data = 64'hDEAD;
        sample();
        checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL exe_only_ready: got %0b want 1", exe_ready); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL exe_only_lsu_ready: got %0b want 0", lsu_ready); end
        step(); exe_valid = 0;
        sample();
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL exe_only_wen: got %0b want 1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL exe_only_waddr: got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 64'hDEAD) begin errors++; $display("FAIL exe_only_wdata: got %h want dead", rf_wdata); end
        step();
        sample();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL idle_wen: got %0b want 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD) begin errors++; $display("FAIL idle_hold: got %0d/%h want 5/dead", rf_waddr, rf_wdata); end
    endtask

    task automatic test_lsu_only();
        step(); lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hBEEF;
        sample();
        checks++; if (lsu_ready !== 1'b1 || exe_ready !== 1'b0) begin errors++; $display("FAIL lsu_only_ready: got lsu=%0b exe=%0b want 1/0", lsu_ready, exe_ready); end
        step(); lsu_valid = 0;
        sample();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 64'hBEEF) begin errors++; $display("FAIL lsu_only_write: got %0b/%0d/%h want 1/4/beef", rf_wen, rf_waddr, rf_wdata); end
    endtask

    task automatic test_round_robin();
        logic [4:0] prev_rd;
        do_reset();
        prev_rd = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            exe_valid = 1; exe_rd = 5'(1 + i); exe_data = 64'(100 + i);
            lsu_valid = 1; lsu_rd = 5'(16 + i); lsu_data = 64'(200 + i);
            sample();
            checks++; if (exe_ready !== ((i % 2) == 0) || lsu_ready !== ((i % 2) == 1)) begin errors++; $display("FAIL rr_grant_%0d: got exe=%0b lsu=%0b", i, exe_ready, lsu_ready); end
            if (i > 0) begin
                checks++; if (rf_wen !== 1'b1 || rf_waddr !== prev_rd) begin errors++; $display("FAIL rr_write_%0d: got %0b/%0d want 1/%0d", i, rf_wen, rf_waddr, prev_rd); end
            end
            prev_rd = ((i % 2) == 0) ? exe_rd : lsu_rd;
        end
        step(); exe_valid = 0; lsu_valid = 0;
        sample();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd19 || rf_wdata !== 64'd203) begin errors++; $display("FAIL rr_last: got %0b/%0d/%0d want 1/19/203", rf_wen, rf_waddr, rf_wdata); end
    endtask

    task automatic test_raw();
        do_reset();
        issue_valid = 1; issue_wen = 1; issue_rd = 7;
        sample();
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue: got %0b want 0", issue_stall); end
        step(); issue_wen = 0; issue_rd = 0; issue_rs1 = 7;
        exe_valid = 1; exe_rd = 7; exe_data = 64'h77;
        sample();
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_busy_stall: got %0b want 1", issue_stall); end
        checks++; if (sb_busy !== 32'h80) begin errors++; $display("FAIL raw_busy_bit: got %h want 00000080", sb_busy); end
        checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL raw_exe_ready: got %0b want 1", exe_ready); end
        step(); exe_valid = 0;
        sample();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL raw_wb: got %0b/%0d want 1/7", rf_wen, rf_waddr); end
`ifdef RF_WB_BYPASS_EN
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_bypass_stall: got %0b want 0", issue_stall); end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 64'h77) begin errors++; $display("FAIL raw_fwd1: got %0b/%h want 1/77", fwd1_hit, fwd1_data); end
`else
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_pend_stall: got %0b want 1", issue_stall); end
`endif
        step();
        sample();
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %0b want 0", issue_stall); end
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL raw_cleared: got %h want 0", sb_busy); end
        step(); issue_valid = 0; issue_rs1 = 0;
    endtask

    task automatic test_rd_zero();
        exe_valid = 1; exe_rd = 0; exe_data = 64'h123;
        issue_valid = 1; issue_wen = 1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        sample();
        checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %0b want 1", exe_ready); end
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL rd0_rs0_stall: got %0b want 0", issue_stall); end
        step(); exe_valid = 0; issue_valid = 0; issue_wen = 0;
        sample();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rd0_wen: got %0b want 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'h123) begin errors++; $display("FAIL rd0_outreg: got %0d/%h want 0/123", rf_waddr, rf_wdata); end
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL rd0_busy: got %h want 0", sb_busy); end
    endtask

    task automatic test_waw();
        step(); issue_valid = 1; issue_wen = 1; issue_rd = 3;
        exe_valid = 1; exe_rd = 3; exe_data = 64'h33;
        sample();
        checks++; if (issue_stall !== 1'b0 || exe_ready !== 1'b1) begin errors++; $display("FAIL waw_first: got stall=%0b ready=%0b want 0/1", issue_stall, exe_ready); end
        step(); exe_valid = 0;
        sample();
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_pend_stall: got %0b want 1", issue_stall); end
        checks++; if (sb_busy !== 32'h8) begin errors++; $display("FAIL waw_busy_set: got %h want 00000008", sb_busy); end
        step();
        sample();
        checks++; if (issue_stall !== 1'b0 || sb_busy !== 32'h0) begin errors++; $display("FAIL waw_after_clear: got stall=%0b busy=%h want 0/0", issue_stall, sb_busy); end
        step(); issue_valid = 0; issue_wen = 0; issue_rd = 0;
        exe_valid = 1; exe_rd = 9; exe_data = 64'h99;
        sample();
        checks++; if (sb_busy !== 32'h8) begin errors++; $display("FAIL waw_reissue_busy: got %h want 00000008", sb_busy); end
        step(); exe_valid = 0;
        sample();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL notbusy_write: got %0b/%0d want 1/9", rf_wen, rf_waddr); end
        step();
        sample();
        checks++; if (sb_busy !== 32'h8) begin errors++; $display("FAIL notbusy_busy: got %h want 00000008", sb_busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            issue_valid = 1; issue_wen = 1; issue_rd = 5'(8 + i);
            sample();
            checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL mid_issue_%0d: got %0b want 0", i, issue_stall); end
        end
        step(); issue_valid = 0; issue_wen = 0; issue_rd = 0;
        exe_valid = 1; exe_rd = 12; exe_data = 64'hC;
        sample();
        checks++; if (sb_busy !== 32'h0000_0F00) begin errors++; $display("FAIL mid_busy: got %h want 00000f00", sb_busy); end
        step(); rst = 1; exe_rd = 13; lsu_valid = 1; lsu_rd = 14;
        sample();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd12) begin errors++; $display("FAIL mid_pending: got %0b/%0d want 1/12", rf_wen, rf_waddr); end
        checks++; if (exe_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_rst: got %0b/%0b want 0/0", exe_ready, lsu_ready); end
        step();
        sample();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL mid_wen_dropped: got %0b want 0", rf_wen); end
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL mid_busy_clear: got %h want 0", sb_busy); end
        checks++; if (exe_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_hold: got %0b/%0b want 0/0", exe_ready, lsu_ready); end
        step(); rst = 0; clear_inputs();
        sample();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL mid_no_accept: got %0b want 0", rf_wen); end
    endtask

    initial begin
        test_reset();
        test_exe_only();
        test_lsu_only();
        test_round_robin();
        test_raw();
        test_rd_zero();
        test_waw();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry integer register file. Two producers share the register file's single write port: the execute unit (EXE) and the load/store unit (LSU). The block picks one of them per cycle with round-robin priority, registers the write, and tracks in-flight destination registers. It raises an issue stall on RAW and WAW hazards. It sits between the EXE/LSU result paths and the register file write port (`dataIn`/`writeReg`/`regWirteEN`).

## Interface
- XLEN, 64, data width; equals `REG_BUS` width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- exe_valid  in  1  EXE has a result.
- exe_ready  out  1  EXE result accepted this cycle.
- exe_rd  in  5  EXE destination register.
- exe_data  in  XLEN  EXE result.
- lsu_valid / lsu_ready / lsu_rd / lsu_data: same as the EXE set, for the LSU.
- rf_wen  out  1  drives the register file write enable.
- rf_waddr  out  5  drives the register file write address.
- rf_wdata  out  XLEN  drives the register file write data.
- issue_valid  in  1  decoder is presenting an instruction.
- issue_wen  in  1  that instruction writes rd.
- issue_rd, issue_rs1, issue_rs2  in  5 each  register indices.
- issue_stall  out  1  combinational; the instruction must not issue.
- sb_busy  out  32  scoreboard bits, for debug and trace.
- fwd1_hit, fwd2_hit  out  1  present only with `RF_WB_BYPASS_EN`.
- fwd1_data, fwd2_data  out  XLEN  present only with `RF_WB_BYPASS_EN`.

## Operation
- Grant is combinational:
  - Only one source valid: that source is granted.
  - Both sources valid: the source not in `last_grant` is granted.
  - `exe_ready`/`lsu_ready` equal the grant; they are never both 1.
  - Both readys are 0 while rst is high.
- A handshake is `valid && ready`. On a handshake:
  - `last_grant` updates to the granted source.
  - The output register loads {wen = (rd != 0), rd, data}.
- With no handshake, rf_wen is 0 on the next cycle; rf_waddr and rf_wdata hold their previous values.
- An rd = 0 result is accepted but suppressed (rf_wen = 0) and does not touch the scoreboard.
- Scoreboard `busy[31:0]`, where busy[0] is always 0:
  - Set: at the edge ending a cycle with `issue_valid && issue_wen && !issue_stall && issue_rd != 0`, set busy[issue_rd].
  - Clear: at the edge ending a cycle with rf_wen = 1, clear busy[rf_waddr].
  - Same register set and cleared on the same edge: set wins, because the new producer owns it.
  - Clear of a register that is not busy: the write still happens; no error.
- `issue_stall = issue_valid && (raw1 || raw2 || waw)`:
  - rawN = (rsN != 0) && (busy[rsN] || pend(rsN)).
  - waw = issue_wen && (issue_rd != 0) && (busy[issue_rd] || pend(issue_rd)).
  - pend(r) = rf_wen && rf_waddr == r; the write is not yet visible in the register file.

## Timing
- Reset values: rf_wen 0, rf_waddr 0, rf_wdata 0, busy all 0, `last_grant` = LSU (so EXE wins the first tie). fwd outputs are 0.
- Handshake in cycle T → rf_wen = 1 in cycle T+1 → register file updated at the T+2 edge → readable in cycle T+2.
- Throughput: one write per cycle. A continuous dual-valid stream alternates EXE, LSU, EXE, ...
- Reset asserted mid-operation:
  - The pending rf_wen is dropped; it is 0 from the next cycle.
  - All busy bits clear.
  - A result presented during reset is not accepted.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - fwdN_hit = rf_wen && rf_waddr == rsN && rsN != 0; fwdN_data = rf_wdata.
  - pend() is dropped from the raw terms, so a dependent instruction issues in cycle T+1 using the forwarded data.
  - The waw term keeps pend().
- Not defined: fwd ports are absent, and dependents stall through cycle T+1.

## Structure
- Shared constants live in `defines.v`: `REG_BUS`, `ZeroWord`, new `REG_ADDR_W` (5), `NUM_REGS` (32), and source IDs `WB_SRC_EXE` = 0, `WB_SRC_LSU` = 1.
- Sub-module `rf_scoreboard`: busy vector, set/clear logic, and the hazard compare for rs1/rs2/rd. The top holds the arbiter, output register and bypass.

## Test plan
- EXE only, rd = 5, data = 0xDEAD → exe_ready = 1 in the same cycle; next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0xDEAD.
- EXE and LSU valid for 4 cycles right after reset → grants EXE, LSU, EXE, LSU; rf_wen = 1 for 4 consecutive cycles.
- Issue rd = 7, then issue rs1 = 7 → stall until the write completes:
  - Without `RF_WB_BYPASS_EN`: stall is 1 through the rf_wen cycle and 0 the cycle after.
  - With it: stall drops during the rf_wen cycle, with fwd1_hit = 1 and fwd1_data equal to the written value.
- EXE result with rd = 0 → exe_ready = 1, rf_wen stays 0, busy unchanged. Issue rs1 = 0 never stalls.
- busy[3] set; same-cycle writeback to 3 and new issue with rd = 3 (waw via pend must be false here, so drive issue after the clear cycle) → busy[3] remains 1 after the edge.
- Assert rst while rf_wen = 1 and busy = 0x0000_0F00 → the next cycle shows rf_wen = 0, busy = 0, and both readys 0 while rst is high.
